// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with r0 hardwired to zero and a busy scoreboard
// Optional write-to-read forwarding is built when REGFILE_BYPASS_EN is defined.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Set is applied after clear so a new producer supersedes the completing one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
      if (wr_en) busy[wr_addr] <= 1'b0;
      if (busy_set && (busy_addr != '0)) busy[busy_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by reset so outputs stay zero while reset is held.
    assign hit = reset && wr_en && (wr_addr != '0) && (wr_addr == addr);
`else
    assign hit = 1'b0;
`endif

    assign rd_data[g*DATA_W +: DATA_W] = hit ? wr_data :
                                         ((addr == '0) ? '0 : regs[addr]);
    assign rd_busy[g] = busy[addr] & ~hit;
  end

  assign stall = |(rd_en & rd_busy);

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed table-driven bench for regfile_param
// Expectations follow the REGFILE_BYPASS_EN build setting.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_en;
  logic [4:0]  a0, a1;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy_set;
  logic [4:0]  busy_addr;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_addr   ({a1, a0}),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .stall     (stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy_set  (busy_set),
    .busy_addr (busy_addr)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bs;
    logic [4:0]  ba;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        es;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic bs, input logic [4:0] ba, input logic [1:0] re,
                     input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb, input logic es);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.bs = bs; v.ba = ba; v.re = re;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [1:0] eb, input logic es);
    chk("rd_data0", idx, rd_data[31:0], e0);
    chk("rd_data1", idx, rd_data[63:32], e1);
    chk("rd_busy", idx, {30'd0, rd_busy}, {30'd0, eb});
    chk("stall", idx, {31'd0, stall}, {31'd0, es});
  endtask

  initial begin
    reset = 1'b0; rd_en = 2'b11; a0 = 5'd4; a1 = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFF_FFFF; busy_set = 1'b1; busy_addr = 5'd6;

    //   rst we wa  wd              bs ba  re     ra0 ra1 e0                              e1            eb                         es
    add(0, 1, 4,  32'hFFFF_FFFF, 1, 6,  2'b11, 4,  6,  32'h0,                          32'h0,        2'b00,                      0);
    add(0, 1, 7,  32'h1234_0000, 1, 7,  2'b11, 7,  4,  32'h0,                          32'h0,        2'b00,                      0);
    add(1, 1, 4,  32'hF,         0, 0,  2'b00, 4,  0,  BYP ? 32'hF : 32'h0,            32'h0,        2'b00,                      0);
    add(1, 0, 0,  32'h0,         0, 0,  2'b00, 4,  7,  32'hF,                          32'h0,        2'b00,                      0);
    add(1, 1, 0,  32'hDEAD_BEEF, 0, 0,  2'b11, 0,  4,  32'h0,                          32'hF,        2'b00,                      0);
    add(1, 0, 0,  32'h0,         1, 0,  2'b11, 0,  0,  32'h0,                          32'h0,        2'b00,                      0);
    add(1, 0, 0,  32'h0,         0, 0,  2'b11, 0,  0,  32'h0,                          32'h0,        2'b00,                      0);
    add(1, 1, 7,  32'h1234_5678, 0, 0,  2'b00, 7,  4,  BYP ? 32'h1234_5678 : 32'h0,    32'hF,        2'b00,                      0);
    add(1, 0, 0,  32'h0,         0, 0,  2'b00, 7,  4,  32'h1234_5678,                  32'hF,        2'b00,                      0);
    add(1, 0, 0,  32'h0,         1, 9,  2'b10, 7,  9,  32'h1234_5678,                  32'h0,        2'b00,                      0);
    add(1, 0, 0,  32'h0,         0, 0,  2'b10, 7,  9,  32'h1234_5678,                  32'h0,        2'b10,                      1);
    add(1, 0, 0,  32'h0,         0, 0,  2'b10, 7,  9,  32'h1234_5678,                  32'h0,        2'b10,                      1);
    add(1, 0, 0,  32'h0,         0, 0,  2'b01, 7,  9,  32'h1234_5678,                  32'h0,        2'b10,                      0);
    add(1, 1, 9,  32'h99,        0, 0,  2'b10, 7,  9,  32'h1234_5678,                  BYP ? 32'h99 : 32'h0, BYP ? 2'b00 : 2'b10, !BYP);
    add(1, 0, 0,  32'h0,         0, 0,  2'b10, 7,  9,  32'h1234_5678,                  32'h99,       2'b00,                      0);
    add(1, 1, 3,  32'hA5,        1, 3,  2'b01, 3,  9,  BYP ? 32'hA5 : 32'h0,           32'h99,       2'b00,                      0);
    add(1, 0, 0,  32'h0,         0, 0,  2'b01, 3,  3,  32'hA5,                         32'hA5,       2'b11,                      1);
    add(1, 0, 0,  32'h0,         1, 2,  2'b00, 2,  5,  32'h0,                          32'h0,        2'b00,                      0);
    add(1, 0, 0,  32'h0,         1, 5,  2'b11, 2,  5,  32'h0,                          32'h0,        2'b01,                      1);
    add(1, 1, 2,  32'h1,         0, 0,  2'b11, 2,  5,  BYP ? 32'h1 : 32'h0,            32'h0,        BYP ? 2'b10 : 2'b11,        1);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      busy_set = vecs[i].bs; busy_addr = vecs[i].ba; rd_en = vecs[i].re;
      a0 = vecs[i].ra0; a1 = vecs[i].ra1;
      #1;
      chk_all(i, vecs[i].e0, vecs[i].e1, vecs[i].eb, vecs[i].es);
    end

    // r2 written and cleared, r5 still pending; then reset drops between edges.
    @(negedge clk);
    wr_en = 1'b0; busy_set = 1'b0; rd_en = 2'b11; a0 = 5'd2; a1 = 5'd5;
    #1;
    chk_all(100, 32'h1, 32'h0, 2'b10, 1'b1);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77; busy_set = 1'b1; busy_addr = 5'd7;
    #1;
    reset = 1'b0;
    #1;
    chk_all(101, 32'h0, 32'h0, 2'b00, 1'b0);

    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0; busy_set = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a0 = (k == 0) ? 5'd2 : (k == 1) ? 5'd3 : (k == 2) ? 5'd4 : 5'd7;
      a1 = (k == 0) ? 5'd5 : (k == 1) ? 5'd9 : (k == 2) ? 5'd7 : 5'd5;
      #1;
      chk_all(102 + k, 32'h0, 32'h0, 2'b00, 1'b0);
    end

    // First write after release lands on the first rising edge.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hF; a0 = 5'd4; a1 = 5'd0;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk_all(110, 32'hF, 32'h0, 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised, clocked general-purpose register file for the MIPS datapath. It provides NUM_RD combinational read ports and one synchronous write port, with register 0 hardwired to zero. A per-register busy scoreboard tracks pending results such as in-flight loads and flags read hazards to the pipeline control. It sits between decode (reads, busy marking) and write-back (writes, busy clearing).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NUM_RD, 2, number of read ports
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; clears all registers and busy bits
- rd_en  input  NUM_RD  per-port read request; qualifies hazard detection only
- rd_addr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  port i is reading a register with a pending write
- stall  output  1  OR of (rd_en[i] & rd_busy[i]) across all ports
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- busy_set  input  1  mark busy_addr as awaiting a result
- busy_addr  input  ADDR_W  register to mark busy

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits, plus a 2**ADDR_W-bit busy vector.
- Write: on a rising clk with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data. Writes to address 0 are discarded.
- Read: rd_data[i] = regs[rd_addr[i]], combinational. Address 0 always reads 0.
- Busy set: on a rising clk with busy_set=1 and busy_addr!=0, busy[busy_addr] <= 1. busy_set to address 0 is ignored.
- Busy clear: on a rising clk with wr_en=1, busy[wr_addr] <= 0.
- Simultaneous busy_set and wr_en to the same address: set wins, so busy stays 1 (a new producer supersedes the completing one). The data write still occurs.
- rd_busy[i] = busy[rd_addr[i]]. When bypass is compiled in, it is masked to 0 when wr_en=1 and wr_addr==rd_addr[i].
- stall is purely combinational from rd_en, rd_busy and the current state.
- Reads from all ports to the same address are legal and return identical data.

## Timing
- Reset: asynchronous assert. Every register and busy bit is 0 immediately, so rd_data=0, rd_busy=0 and stall=0 while reset=0. Deassertion is sampled synchronously: the first write takes effect at the first rising clk with reset=1.
- Reset during a pending busy or write: everything is cleared, and the in-flight write on that edge is lost.
- Write latency: without bypass, data is visible on rd_data after the write edge (next cycle). With bypass, visible in the same cycle as wr_en.
- Busy latency: rd_busy rises the cycle after the busy_set edge and falls the cycle after the clearing write (same cycle with bypass).
- No handshake back-pressure: the block never refuses a write. Upstream control holds issue while stall=1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i]=wr_data combinationally.
  - rd_busy[i] is masked as described in Operation.
  - A write-back and a dependent read can occur in the same cycle without a stall.
- REGFILE_BYPASS_EN undefined:
  - rd_data always comes from storage (write-then-read requires one cycle).
  - rd_busy reflects the busy vector only.

## Test plan
- Reset low with random inputs -> all rd_data=0 and stall=0. Then reset high, write 32'hF to r4, read r4 next cycle -> 32'h0000000F.
- wr_en=1, wr_addr=0, wr_data=32'hDEADBEEF, then read r0 -> 0. Then busy_set for r0 with rd_en=1 -> stall=0.
- Write 32'h12345678 to r7 and read r7 in the same cycle:
  - Bypass build -> 32'h12345678 that cycle.
  - Non-bypass build -> old value that cycle, 32'h12345678 the next.
- busy_set r9, then rd_en[1]=1 and rd_addr1=9 -> stall=1 until the write to r9. Then stall=0, in the same cycle if bypass is built in, otherwise the next cycle.
- busy_set r3 and wr_en r3 (32'hA5) on the same edge -> r3=32'hA5 and busy[3]=1; a read of r3 with rd_en still stalls.
- Set busy on r2 and r5, write r2=32'h1, then drop reset mid-cycle -> rd_data=0 and stall=0 immediately; after release, all reads return 0.
